// File: rtl/audio_feed_i2c_master.sv
// Write-only I2C master: START, address+W, two payload bytes with ACK checks, STOP.
// Optional SCL clock stretching is enabled by defining I2C_CLOCK_STRETCH_EN.
module audio_feed_i2c_master #(
  parameter int unsigned CLK_DIV = 125
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [6:0]  dev_addr,
  input  logic [15:0] tx_data,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        scl_oe,
  output logic        sda_oe,
  input  logic        sda_in,
  input  logic        scl_in
);

  typedef enum logic [2:0] {StIdle, StStart, StBit, StAck, StStop, StDone} state_e;

  localparam logic [11:0] CntLast = 12'(CLK_DIV - 1);

  state_e      state_q, state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [6:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic        ack_err_q, ack_err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        scl_oe_q, scl_oe_d;
  logic        sda_oe_q, sda_oe_d;
  logic        freeze;
  logic        qtr_end;
  logic [7:0]  sel_byte;
  logic        cur_bit;

`ifdef I2C_CLOCK_STRETCH_EN
  // A slave holding SCL low after release pauses the high phase.
  assign freeze = !scl_in && (qtr_q == 2'd1) &&
                  (state_q == StBit || state_q == StAck || state_q == StStop);
`else
  logic unused_scl_in;
  assign unused_scl_in = scl_in;
  assign freeze = 1'b0;
`endif

  assign qtr_end = (cnt_q == CntLast) && !freeze;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    qtr_d     = qtr_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    addr_d    = addr_q;
    data_d    = data_q;
    ack_err_d = ack_err_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        qtr_d = '0;
        if (start) begin
          state_d   = StStart;
          addr_d    = dev_addr;
          data_d    = tx_data;
          ack_err_d = 1'b0;
          bit_d     = 3'd7;
          byte_d    = 2'd0;
        end
      end
      StStart, StBit, StAck, StStop: begin
        if (!freeze) cnt_d = qtr_end ? '0 : cnt_q + 12'd1;
        if (qtr_end) begin
          qtr_d = qtr_q + 2'd1;
          // ACK is sampled at the end of the SCL high phase.
          if (state_q == StAck && qtr_q == 2'd2 && sda_in) ack_err_d = 1'b1;
          if (qtr_q == 2'd3) begin
            case (state_q)
              StStart: state_d = StBit;
              StBit: begin
                if (bit_q == 3'd0) state_d = StAck;
                else bit_d = bit_q - 3'd1;
              end
              StAck: begin
                bit_d = 3'd7;
                if (ack_err_q || byte_q == 2'd2) begin
                  state_d = StStop;
                end else begin
                  state_d = StBit;
                  byte_d  = byte_q + 2'd1;
                end
              end
              StStop:  state_d = StDone;
              default: state_d = StIdle;
            endcase
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are derived from the next state so they register in step with it.
  always_comb begin
    unique case (byte_d)
      2'd0:    sel_byte = {addr_d, 1'b0};
      2'd1:    sel_byte = data_d[15:8];
      default: sel_byte = data_d[7:0];
    endcase
    cur_bit  = sel_byte[bit_d];
    busy_d   = state_d inside {StStart, StBit, StAck, StStop};
    done_d   = (state_d == StDone);
    scl_oe_d = 1'b0;
    sda_oe_d = 1'b0;
    unique case (state_d)
      StStart: begin
        scl_oe_d = (qtr_d >= 2'd2);
        sda_oe_d = (qtr_d != 2'd0);
      end
      StBit: begin
        scl_oe_d = (qtr_d == 2'd0) || (qtr_d == 2'd3);
        sda_oe_d = ~cur_bit;
      end
      StAck: begin
        scl_oe_d = (qtr_d == 2'd0) || (qtr_d == 2'd3);
        sda_oe_d = 1'b0;
      end
      StStop: begin
        scl_oe_d = (qtr_d == 2'd0);
        sda_oe_d = (qtr_d <= 2'd1);
      end
      default: begin
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      qtr_q     <= '0;
      bit_q     <= 3'd7;
      byte_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      ack_err_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      scl_oe_q  <= 1'b0;
      sda_oe_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      qtr_q     <= qtr_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ack_err_q <= ack_err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      scl_oe_q  <= scl_oe_d;
      sda_oe_q  <= sda_oe_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign ack_err = ack_err_q;
  assign scl_oe  = scl_oe_q;
  assign sda_oe  = sda_oe_q;

endmodule

// File: tb/tb_audio_feed_i2c_master.sv
// Scoreboard bench for audio_feed_i2c_master: a bus monitor/slave model decodes the
// wires and compares each completed transaction against expectations queued at issue.
`timescale 1ns/1ps
module tb_audio_feed_i2c_master;

  localparam int unsigned ClkDiv = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  dev_addr;
  logic [15:0] tx_data;
  logic        busy, done, ack_err, scl_oe, sda_oe;
  logic        sda_in, scl_in;
  logic        slave_pull = 1'b0;
  logic        stretch_hold = 1'b0;

  always #5 clk = ~clk;

  // Open-drain wires: a line is high unless someone pulls it low.
  assign scl_in = ~scl_oe & ~stretch_hold;
  assign sda_in = ~sda_oe & ~slave_pull;

  audio_feed_i2c_master #(.CLK_DIV(ClkDiv)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dev_addr (dev_addr),
    .tx_data  (tx_data),
    .busy     (busy),
    .done     (done),
    .ack_err  (ack_err),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe),
    .sda_in   (sda_in),
    .scl_in   (scl_in)
  );

  typedef struct {
    int          nbytes;
    logic [23:0] bytes;
    logic        ack_err;
    int          busy_cycles;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] obs_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int nack_at = 3;
  int stretch_req = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor, slave model and scoreboard checker.
  int         busy_cnt = 0;
  int         nbits = 0;
  int         byte_idx = 0;
  int         rise_cnt = 0;
  int         hold_left = 0;
  logic [7:0] shreg = '0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       prev_scl_oe = 1'b0;
  logic       scl_l, sda_l;
  exp_t       e;

  always @(negedge clk) begin
    scl_l = scl_in;
    sda_l = sda_in;
    if (reset) begin
      nbits = 0; byte_idx = 0; rise_cnt = 0; hold_left = 0; busy_cnt = 0;
      slave_pull = 1'b0; stretch_hold = 1'b0;
      obs_q.delete();
      exp_q.delete();
    end else begin
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) stretch_hold = 1'b0;
      end
      if (prev_scl_oe && !scl_oe) begin
        rise_cnt++;
        if (stretch_req > 0 && rise_cnt == 4) begin
          stretch_hold = 1'b1;
          hold_left    = stretch_req;
          stretch_req  = 0;
        end
      end
      if (prev_scl && scl_l && prev_sda && !sda_l) begin
        nbits = 0; byte_idx = 0; rise_cnt = 0;
        obs_q.delete();
      end
      if (!prev_scl && scl_l) begin
        if (nbits < 8) shreg = {shreg[6:0], sda_l};
        nbits++;
        if (nbits == 8) obs_q.push_back(shreg);
        if (nbits == 9) begin
          nbits = 0;
          byte_idx++;
        end
      end
      if (prev_scl && !scl_l) slave_pull = (nbits == 8) && (byte_idx != nack_at);
      if (busy) busy_cnt++;
      if (done) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got a done pulse, expected none");
        end else begin
          e = exp_q.pop_front();
          check("busy_cycles", busy_cnt, e.busy_cycles);
          check("ack_err", ack_err, e.ack_err);
          check("byte_count", obs_q.size(), e.nbytes);
          for (int i = 0; i < e.nbytes && i < obs_q.size(); i++)
            check("sda_byte", obs_q[i], e.bytes[23 - 8*i -: 8]);
          check("oe_at_done", {scl_oe, sda_oe}, 0);
        end
        busy_cnt = 0;
        obs_q.delete();
      end
    end
    prev_scl    = scl_l;
    prev_sda    = sda_l;
    prev_scl_oe = scl_oe;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command; nk = byte index the slave NACKs (3 = none).
  task automatic issue(input logic [6:0] a, input logic [15:0] d, input int nk,
                       input int stretch, input bit inject);
    exp_t x;
    int   n;
    n = (nk <= 2) ? nk + 1 : 3;
    x.nbytes      = n;
    x.bytes       = {a, 1'b0, d};
    x.ack_err     = (nk <= 2);
    x.busy_cycles = (8 + 36 * n) * ClkDiv + stretch;
    nack_at     = nk;
    stretch_req = stretch;
    dev_addr    = a;
    tx_data     = d;
    start       = 1'b1;
    exp_q.push_back(x);
    tick();
    start = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_ack_err_clear", ack_err, 0);
    for (int i = 1; i < 3000 && exp_q.size() != 0; i++) begin
      if (inject && (i == 10 || i == 50)) begin
        start    = 1'b1;
        dev_addr = ~a;
        tx_data  = ~d;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got no done within 3000 cycles, expected one");
      exp_q.delete();
    end
  endtask

  initial begin
    int r;
    reset = 1'b1; start = 1'b0; dev_addr = '0; tx_data = '0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ack_err", ack_err, 0);
    check("rst_oe", {scl_oe, sda_oe}, 0);
    reset = 1'b0;
    tick();

    issue(7'h1A, 16'h1E00, 3, 0, 1'b0);
    issue(7'h1A, 16'h1E00, 0, 0, 1'b0);
    issue(7'h1A, 16'h1E00, 1, 0, 1'b0);
    check("ack_err_sticky", ack_err, 1);
    issue(7'h55, 16'hA5C3, 3, 0, 1'b1);

    // Reset wins over a simultaneous start.
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    check("rst_start_busy", busy, 0);
    tick();
    check("rst_start_busy2", busy, 0);

    // Reset in the middle of byte1.
    nack_at = 3; dev_addr = 7'h1A; tx_data = 16'h1E00; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (52 * ClkDiv) tick();
    check("mid_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_oe", {scl_oe, sda_oe}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    repeat (20) tick();
    issue(7'h1A, 16'h1E00, 3, 0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      r = $urandom_range(0, 5);
      issue(7'($urandom), 16'($urandom), (r > 2) ? 3 : r, 0, 1'b0);
    end

`ifdef I2C_CLOCK_STRETCH_EN
    issue(7'h1A, 16'h1E00, 3, 50, 1'b0);
`endif

    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_feed_i2c_master.md
Name: audio_feed_i2c_master

Overview:
Write-only I2C master that sequences the codec configuration bus, replacing software bit-banging of the SDA/SCL PIO ports. Takes one command (7-bit device address plus 16-bit payload) and emits START, address+W, two data bytes and STOP, checking ACK after each byte. Payload format matches the WM8731 register write (7-bit register, 9-bit value). Drives open-drain enables for the top-level SDA/SCL tristate buffers.

Parameters:
CLK_DIV, 125, clk cycles per quarter SCL period (125 gives 100 kHz at 50 MHz); legal range 2..4095

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  command request; accepted only while busy=0
dev_addr  in  7  7-bit slave address, latched on accept
tx_data  in  16  payload; byte1=tx_data[15:8], byte2=tx_data[7:0]; latched on accept
busy  out  1  transaction in progress
done  out  1  one-cycle completion pulse
ack_err  out  1  NACK seen in last transaction; sticky until next accept
scl_oe  out  1  1 pulls SCL low, 0 releases it
sda_oe  out  1  1 pulls SDA low, 0 releases it
sda_in  in  1  SDA pad level
scl_in  in  1  SCL pad level (used only with the optional feature)

Behaviour:
- Reset: busy=0, done=0, ack_err=0, scl_oe=0, sda_oe=0, FSM=IDLE, quarter counter=0. Reset wins over start in the same cycle.
- Accept: start=1 while IDLE latches the inputs. busy=1 and ack_err=0 from the next cycle. Start while busy is ignored.
- Quarter timing: each quarter lasts exactly CLK_DIV cycles. The first quarter begins in the cycle busy rises. The counter is held at 0 in IDLE.
- FSM states: IDLE, START, BIT, ACK, STOP, DONE.
- START (4 quarters):
  - q0: SDA and SCL released.
  - q1: sda_oe=1.
  - q2 and q3: scl_oe=1.
- BIT (4 quarters per bit, MSB first):
  - q0: scl_oe=1, sda_oe=~bit.
  - q1 and q2: scl_oe=0.
  - q3: scl_oe=1.
  - Byte order: address byte = {dev_addr,1'b0}, then byte1, then byte2.
- ACK (4 quarters, same SCL pattern as BIT):
  - sda_oe=0 throughout.
  - sda_in is sampled in the last cycle of q2; 0 means ACK.
  - NACK: ack_err=1, skip remaining bytes, go to STOP.
  - ACK after byte2: go to STOP.
- STOP (4 quarters):
  - q0: scl_oe=1, sda_oe=1.
  - q1: scl_oe=0.
  - q2 and q3: SDA released.
- DONE: busy=0 and done=1 for one cycle, then IDLE. ack_err holds its value.
- Busy duration:
  - Full transaction: 116 quarters (4+27*4+4), i.e. busy high for exactly 116*CLK_DIV cycles.
  - NACK on address: 44 quarters.
  - NACK on byte1: 80 quarters.
- SDA changes only while SCL is driven low, except the START q1 and STOP q2 edges.
- Mid-operation reset: scl_oe=sda_oe=0 and busy=0 in the cycle after reset is sampled. No done pulse. A slave left mid-byte recovers on the next START.
- Arbitration loss and multi-master operation are not supported.

Optional Feature:
- Macro: I2C_CLOCK_STRETCH_EN.
- Defined: in q1 of every BIT/ACK quarter sequence and STOP q1, the quarter counter freezes while scl_in=0. It resumes counting when scl_in=1. Busy extends by exactly the number of frozen cycles.
- Undefined: scl_in is ignored and timing is fixed as above.

Test Plan:
- CLK_DIV=4, dev_addr=0x1A, tx_data=0x1E00, slave ACKs all -> SDA sampled at SCL rises = 0x34,0x1E,0x00; busy high 464 cycles; done pulses once; ack_err=0.
- Same command, sda_in=1 during the address ACK -> ack_err=1; STOP issued; busy 176 cycles; both OEs 0 after done.
- NACK only on byte1 -> ack_err=1; byte2 never shifted; busy 320 cycles; ack_err cleared in the cycle after the next accepted start.
- start pulsed at cycles 10 and 50 of a busy transaction -> ignored, exactly one done; start and reset asserted together -> busy stays 0.
- Reset asserted mid byte1 -> next cycle scl_oe=0, sda_oe=0, busy=0, no done; a new start then completes normally.
- I2C_CLOCK_STRETCH_EN defined, scl_in held 0 for 50 cycles in bit 3 q1 -> SCL high phase delayed; busy = 464+50 cycles; data intact.
